bus_share_arbiter: RTL and testbench

- Two-requester arbiter that owns the select of the shared WIDTH-bit 2:1 bus mux: source A when c=0, source B when c=1.
- Sequences ownership with round-robin fairness, a bounded hold time under contention, and back-to-back handoff.
- Drives per-requester grants, the mux select c, and a registered bus output p with a valid flag.
- Sits between the two bus masters and the mux datapath; it is the only driver of c.

---
 rtl/bus_share_arbiter.sv | 67 ++++++
 tb/tb_bus_share_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_share_arbiter.sv
// bus_share_arbiter: two-requester round-robin bus arbiter with bounded hold and registered mux output; BUS_PARK_EN parks c on last owner in IDLE
module bus_share_arbiter #(
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             c,
    output logic [WIDTH-1:0] p,
    output logic             p_valid
);
    localparam int HW = MAX_HOLD > 1 ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);
    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;
    state_t           state_q, state_d;
    logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
    logic             last_q, last_d, c_q, c_d, p_valid_q, p_valid_d, entering;
    logic [WIDTH-1:0] p_q, p_d;
    assign gnt_a   = state_q == OWN_A;
    assign gnt_b   = state_q == OWN_B;
    assign c       = c_q;
    assign p       = p_q;
    assign p_valid = p_valid_q;
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (req_a && req_b) ? (last_q ? OWN_A : OWN_B) : req_a ? OWN_A : req_b ? OWN_B : IDLE;
            OWN_A:   state_d = !req_a ? (req_b ? OWN_B : IDLE) : (req_b && hold_cnt_q == HOLD_MAX) ? OWN_B : OWN_A;
            OWN_B:   state_d = !req_b ? (req_a ? OWN_A : IDLE) : (req_a && hold_cnt_q == HOLD_MAX) ? OWN_A : OWN_B;
            default: state_d = IDLE;
        endcase
        entering   = state_d != IDLE && state_d != state_q;
        hold_cnt_d = entering ? '0 : (state_q != IDLE && hold_cnt_q != HOLD_MAX) ? hold_cnt_q + HW'(1) : hold_cnt_q;
        last_d     = entering ? state_d == OWN_B : last_q;
`ifdef BUS_PARK_EN
        c_d = state_d == IDLE ? c_q : state_d == OWN_B;
        p_d = c_q ? b : a;
`else
        c_d = state_d == OWN_B;
        p_d = state_q == IDLE ? '0 : (c_q ? b : a);
`endif
        p_valid_d = (gnt_a & req_a) | (gnt_b & req_b);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            last_q     <= 1'b1;
            c_q        <= 1'b0;
            p_q        <= '0;
            p_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            last_q     <= last_d;
            c_q        <= c_d;
            p_q        <= p_d;
            p_valid_q  <= p_valid_d;
        end
    end
endmodule

// File: tb/tb_bus_share_arbiter.sv
// tb_bus_share_arbiter: directed checks of grants, round-robin, hold limit, handoff and bus parking
module tb_bus_share_arbiter;
    logic       clk = 1'b0;
    logic       rst, req_a, req_b, gnt_a, gnt_b, c, p_valid;
    logic [3:0] a, b, p;
    int         total = 0;
    int         bad = 0;
    bus_share_arbiter #(.WIDTH(4), .MAX_HOLD(8)) dut (
        .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .a(a), .b(b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .c(c), .p(p), .p_valid(p_valid)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask
    task automatic test_reset();
        rst = 1'b1; req_a = 1'b1; req_b = 1'b0; a = 4'h5; b = 4'h0;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if ({gnt_a, gnt_b, c, p, p_valid} !== 8'h00) begin
                bad++; $display("FAIL reset_outputs cycle=%0d got=%b want=00000000", i, {gnt_a, gnt_b, c, p, p_valid});
            end
        end
        rst = 1'b0;
        tick();
        total++;
        if ({gnt_a, gnt_b, c} !== 3'b100) begin
            bad++; $display("FAIL reset_first_grant got=%b want=100", {gnt_a, gnt_b, c});
        end
        tick();
        total++;
        if ({p, p_valid} !== {4'h5, 1'b1}) begin
            bad++; $display("FAIL reset_first_data p=%h v=%b want p=5 v=1", p, p_valid);
        end
        req_a = 1'b0;
        tick();
        tick();
    endtask
    task automatic test_req_b();
        req_b = 1'b1; b = 4'hA; a = 4'h0;
        tick();
        total++;
        if ({gnt_a, gnt_b, c} !== 3'b011) begin
            bad++; $display("FAIL req_b_grant got=%b want=011", {gnt_a, gnt_b, c});
        end
        tick();
        total++;
        if ({p, p_valid} !== {4'hA, 1'b1}) begin
            bad++; $display("FAIL req_b_data p=%h v=%b want p=a v=1", p, p_valid);
        end
        req_b = 1'b0;
        tick();
        tick();
    endtask
    task automatic test_tie();
        req_a = 1'b1; req_b = 1'b1;
        tick();
        total++;
        if ({gnt_a, gnt_b} !== 2'b10) begin
            bad++; $display("FAIL tie_after_b got=%b want=10", {gnt_a, gnt_b});
        end
        req_a = 1'b0; req_b = 1'b0;
        tick();
        req_a = 1'b1; req_b = 1'b1;
        tick();
        total++;
        if ({gnt_a, gnt_b} !== 2'b01) begin
            bad++; $display("FAIL tie_after_a got=%b want=01", {gnt_a, gnt_b});
        end
        req_a = 1'b0; req_b = 1'b0;
        tick();
    endtask
    task automatic test_contention();
        logic ob;
        do_reset();
        req_a = 1'b1; req_b = 1'b1; a = 4'h1; b = 4'h2;
        for (int i = 1; i <= 32; i++) begin
            tick();
            ob = ((i - 1) / 8) % 2 == 1;
            total++;
            if ({gnt_a, gnt_b, c} !== {!ob, ob, ob}) begin
                bad++; $display("FAIL contention cycle=%0d got=%b want=%b", i, {gnt_a, gnt_b, c}, {!ob, ob, ob});
            end
        end
        req_a = 1'b0; req_b = 1'b0;
        tick();
        tick();
    endtask
    task automatic test_back_to_back();
        do_reset();
        req_a = 1'b1; req_b = 1'b1;
        tick(); tick(); tick();
        req_a = 1'b0;
        tick();
        total++;
        if ({gnt_a, gnt_b, c} !== 3'b011) begin
            bad++; $display("FAIL handoff got=%b want=011", {gnt_a, gnt_b, c});
        end
        req_a = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            total++;
            if ({gnt_a, gnt_b} !== 2'b01) begin
                bad++; $display("FAIL handoff_hold cycle=%0d got=%b want=01", i, {gnt_a, gnt_b});
            end
        end
        tick();
        total++;
        if ({gnt_a, gnt_b} !== 2'b10) begin
            bad++; $display("FAIL handoff_preempt got=%b want=10", {gnt_a, gnt_b});
        end
        req_a = 1'b0; req_b = 1'b0;
        tick();
        tick();
    endtask
    task automatic test_no_preempt();
        do_reset();
        req_a = 1'b1; a = 4'h7;
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if (gnt_a !== 1'b1) begin
                bad++; $display("FAIL no_preempt cycle=%0d gnt_a=%b want=1", i, gnt_a);
            end
        end
        total++;
        if ({p, p_valid} !== {4'h7, 1'b1}) begin
            bad++; $display("FAIL no_preempt_data p=%h v=%b want p=7 v=1", p, p_valid);
        end
        req_a = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if ({gnt_a, gnt_b, p_valid} !== 3'b000) begin
                bad++; $display("FAIL release cycle=%0d got=%b want=000", i, {gnt_a, gnt_b, p_valid});
            end
        end
    endtask
    task automatic test_park();
        do_reset();
        req_b = 1'b1; b = 4'h3; a = 4'h9;
        tick();
        tick();
        req_b = 1'b0;
        tick();
        total++;
        if ({gnt_b, p, p_valid} !== {1'b0, 4'h3, 1'b0}) begin
            bad++; $display("FAIL park_release got gnt_b=%b p=%h v=%b want 0 3 0", gnt_b, p, p_valid);
        end
        tick();
        total++;
`ifdef BUS_PARK_EN
        if ({c, p, p_valid} !== {1'b1, 4'h3, 1'b0}) begin
            bad++; $display("FAIL park_idle got c=%b p=%h v=%b want 1 3 0", c, p, p_valid);
        end
`else
        if ({c, p, p_valid} !== {1'b0, 4'h0, 1'b0}) begin
            bad++; $display("FAIL park_idle got c=%b p=%h v=%b want 0 0 0", c, p, p_valid);
        end
`endif
        req_b = 1'b1;
        tick();
        total++;
        if ({gnt_a, gnt_b, c} !== 3'b011) begin
            bad++; $display("FAIL park_regrant got=%b want=011", {gnt_a, gnt_b, c});
        end
    endtask
    task automatic test_reset_mid();
        req_a = 1'b1; req_b = 1'b1; rst = 1'b1;
        tick();
        total++;
        if ({gnt_a, gnt_b, c, p, p_valid} !== 8'h00) begin
            bad++; $display("FAIL reset_mid got=%b want=00000000", {gnt_a, gnt_b, c, p, p_valid});
        end
        rst = 1'b0;
        tick();
        total++;
        if ({gnt_a, gnt_b, c} !== 3'b100) begin
            bad++; $display("FAIL reset_mid_tie got=%b want=100", {gnt_a, gnt_b, c});
        end
        req_a = 1'b0; req_b = 1'b0;
        tick();
    endtask
    initial begin
        test_reset();
        test_req_b();
        test_tie();
        test_contention();
        test_back_to_back();
        test_no_preempt();
        test_park();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
